// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - host-side configuration and receive-stream bundle for uart_rx_ctrl
interface uart_rx_ctrl_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int scaler_width = 5,
   parameter int FIFO_DEPTH   = 4
);
   logic                          cfg_req;
   logic [scaler_width-1:0]       cfg_prescale;
   logic                          cfg_par_en;
   logic                          cfg_par_typ;
   logic                          cfg_busy;
   logic                          cfg_ack;
   logic                          cfg_err;
   logic [DATA_WIDTH-1:0]         m_data;
   logic                          m_valid;
   logic                          m_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          overflow;
   logic                          ovf_clr;

   modport master (
      output cfg_req, cfg_prescale, cfg_par_en, cfg_par_typ, m_ready, ovf_clr,
      input  cfg_busy, cfg_ack, cfg_err, m_data, m_valid, fifo_count, overflow
   );

   modport slave (
      input  cfg_req, cfg_prescale, cfg_par_en, cfg_par_typ, m_ready, ovf_clr,
      output cfg_busy, cfg_ack, cfg_err, m_data, m_valid, fifo_count, overflow
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver config sequencer with idle-gated apply and show-ahead byte FIFO
module uart_rx_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int scaler_width = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int IDLE_BITS    = 11,
   parameter int RST_PRESCALE = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   uart_rx_ctrl_if.slave           host,
   input  logic                    RX_IN,
   output logic [scaler_width-1:0] Prescale,
   output logic                    PAR_EN,
   output logic                    PAR_TYP,
   output logic                    rx_rst,
   input  logic [DATA_WIDTH-1:0]   P_DATA,
   input  logic                    data_valid
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(IDLE_BITS * ((1 << scaler_width) - 1) + 1);

   typedef enum logic [1:0] {RUN, WAIT_IDLE, APPLY} state_t;

   state_t                  state_q, state_d;
   logic [scaler_width-1:0] prescale_q, prescale_d;
   logic [scaler_width-1:0] pend_prescale_q, pend_prescale_d;
   logic                    par_en_q, par_en_d, pend_par_en_q, pend_par_en_d;
   logic                    par_typ_q, par_typ_d, pend_par_typ_q, pend_par_typ_d;
   logic                    rx_rst_q, rx_rst_d;
   logic                    cfg_busy_q, cfg_busy_d;
   logic                    cfg_ack_q, cfg_ack_d;
   logic                    cfg_err_q, cfg_err_d;
   logic [CW-1:0]           idle_cnt_q, idle_cnt_d;
   logic [CW-1:0]           idle_target;
   logic                    cfg_legal;

   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q, count_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic                    m_valid_q, m_valid_d;
   logic                    overflow_q, overflow_d;
   logic                    full, push, pop, push_ok, drop;

   always_comb begin
      state_d         = state_q;
      prescale_d      = prescale_q;
      par_en_d        = par_en_q;
      par_typ_d       = par_typ_q;
      pend_prescale_d = pend_prescale_q;
      pend_par_en_d   = pend_par_en_q;
      pend_par_typ_d  = pend_par_typ_q;
      idle_cnt_d      = idle_cnt_q;
      cfg_ack_d       = 1'b0;
      cfg_err_d       = 1'b0;
      // Idle window is measured in bit periods of the configuration still in force.
      idle_target     = CW'(IDLE_BITS) * CW'(prescale_q);
      cfg_legal       = (host.cfg_prescale == scaler_width'(8)) ||
                        (host.cfg_prescale == scaler_width'(16));

      case (state_q)
         RUN: begin
            if (host.cfg_req) begin
               if (cfg_legal) begin
                  pend_prescale_d = host.cfg_prescale;
                  pend_par_en_d   = host.cfg_par_en;
                  pend_par_typ_d  = host.cfg_par_typ;
                  idle_cnt_d      = '0;
                  state_d         = WAIT_IDLE;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            if (idle_cnt_q == idle_target) begin
               state_d = APPLY;
            end else if (RX_IN) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end else begin
               idle_cnt_d = '0;
            end
         end
         APPLY:   state_d = RUN;
         default: state_d = RUN;
      endcase

      if (state_d == APPLY) begin
         prescale_d = pend_prescale_q;
         par_en_d   = pend_par_en_q;
         par_typ_d  = pend_par_typ_q;
         cfg_ack_d  = 1'b1;
      end
      rx_rst_d   = (state_d == APPLY);
      cfg_busy_d = (state_d != RUN);
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      m_data_d = m_data_q;
      full     = (count_q == (AW+1)'(FIFO_DEPTH));
      pop      = m_valid_q && host.m_ready;
      // The core is held in reset during the apply cycle, so its strobe is not trusted.
      push     = data_valid && (state_q != APPLY);
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;

      if (push_ok) begin
         mem_d[wr_ptr_q] = P_DATA;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

      // Head register tracks the entry at rd_ptr so m_data stays a flop output.
      if (pop) begin
         m_data_d = (count_q > (AW+1)'(1)) ? mem_q[rd_ptr_q + 1'b1] : P_DATA;
      end else if (count_q == '0) begin
         m_data_d = P_DATA;
      end
      m_valid_d  = (count_d != '0);
      overflow_d = drop | (overflow_q & ~host.ovf_clr);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= RUN;
         prescale_q      <= scaler_width'(RST_PRESCALE);
         par_en_q        <= 1'b1;
         par_typ_q       <= 1'b0;
         pend_prescale_q <= scaler_width'(RST_PRESCALE);
         pend_par_en_q   <= 1'b1;
         pend_par_typ_q  <= 1'b0;
         rx_rst_q        <= 1'b1;
         cfg_busy_q      <= 1'b0;
         cfg_ack_q       <= 1'b0;
         cfg_err_q       <= 1'b0;
         idle_cnt_q      <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         m_data_q        <= '0;
         m_valid_q       <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         prescale_q      <= prescale_d;
         par_en_q        <= par_en_d;
         par_typ_q       <= par_typ_d;
         pend_prescale_q <= pend_prescale_d;
         pend_par_en_q   <= pend_par_en_d;
         pend_par_typ_q  <= pend_par_typ_d;
         rx_rst_q        <= rx_rst_d;
         cfg_busy_q      <= cfg_busy_d;
         cfg_ack_q       <= cfg_ack_d;
         cfg_err_q       <= cfg_err_d;
         idle_cnt_q      <= idle_cnt_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         m_data_q        <= m_data_d;
         m_valid_q       <= m_valid_d;
         overflow_q      <= overflow_d;
      end
      mem_q <= mem_d;
   end

   assign Prescale        = prescale_q;
   assign PAR_EN          = par_en_q;
   assign PAR_TYP         = par_typ_q;
   assign rx_rst          = rx_rst_q;
   assign host.cfg_busy   = cfg_busy_q;
   assign host.cfg_ack    = cfg_ack_q;
   assign host.cfg_err    = cfg_err_q;
   assign host.m_data     = m_data_q;
   assign host.m_valid    = m_valid_q;
   assign host.fifo_count = count_q;
   assign host.overflow   = overflow_q;
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block between the host and the UART receiver core. It holds the receiver configuration (Prescale, PAR_EN, PAR_TYP). Host reconfiguration requests are applied only after the serial line has been idle long enough, and the receiver core is held in reset for the switch-over cycle. Received bytes (P_DATA/data_valid) are captured into a small show-ahead FIFO with a valid/ready output and a sticky overflow flag.

## Interface
- DATA_WIDTH, 8, receiver data width
- scaler_width, 5, Prescale width
- FIFO_DEPTH, 4, output FIFO entries (power of two)
- IDLE_BITS, 11, bit periods RX_IN must stay high before a new config is applied
- RST_PRESCALE, 8, Prescale value after reset

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- cfg_req  in  1  single-cycle configuration request pulse
- cfg_prescale  in  scaler_width  requested Prescale; legal values 8 and 16 only
- cfg_par_en  in  1  requested parity enable
- cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
- cfg_busy  out  1  high while a request is pending (state != RUN)
- cfg_ack  out  1  one-cycle pulse; new config visible on outputs this cycle
- cfg_err  out  1  one-cycle pulse; request rejected
- RX_IN  in  1  serial line, monitored for idle only
- Prescale  out  scaler_width  to receiver core
- PAR_EN  out  1  to receiver core
- PAR_TYP  out  1  to receiver core
- rx_rst  out  1  active-high reset to receiver core
- P_DATA  in  DATA_WIDTH  received byte from core
- data_valid  in  1  byte strobe from core
- m_data  out  DATA_WIDTH  FIFO head
- m_valid  out  1  FIFO not empty
- m_ready  in  1  host accepts head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky; byte dropped on full FIFO
- ovf_clr  in  1  clears overflow

## Operation
- FSM states: RUN, WAIT_IDLE, APPLY.
- RUN: on cfg_req:
  - Legal request: latch cfg_prescale/cfg_par_en/cfg_par_typ into pending registers and go to WAIT_IDLE.
  - Illegal prescale (not 8 or 16): cfg_err next cycle, stay in RUN, no register change.
- WAIT_IDLE:
  - idle_cnt increments each cycle RX_IN==1 and clears to 0 on any cycle RX_IN==0.
  - Go to APPLY when idle_cnt reaches IDLE_BITS*Prescale, using the current (old) Prescale.
  - Count width must hold IDLE_BITS*(2^scaler_width-1) without wrap.
  - Core keeps running; bytes are still captured.
- APPLY (exactly one cycle): Prescale/PAR_EN/PAR_TYP take the pending values, rx_rst=1, then return to RUN.
- cfg_req while cfg_busy: ignored; no cfg_err, pending values unchanged.
- FIFO push: data_valid==1 and state != APPLY pushes P_DATA. data_valid is ignored during APPLY, when the core is in reset.
- FIFO pop: m_valid && m_ready.
- Full FIFO with data_valid and no pop: byte dropped, overflow set.
- Full FIFO with push and pop in the same cycle: both occur; count unchanged; no overflow.
- Empty FIFO with push and m_ready: push only; m_valid is not combinationally bypassed.
- overflow clears on ovf_clr. If set and clear coincide, set wins.
- FIFO contents persist across reconfiguration.
- RST mid-request: pending request is discarded, FIFO is flushed, all outputs return to reset values.

## Timing
- Reset values:
  - Prescale=RST_PRESCALE, PAR_EN=1, PAR_TYP=0.
  - rx_rst=1, cfg_busy=0, cfg_ack=0, cfg_err=0.
  - m_valid=0, fifo_count=0, overflow=0; m_data undefined (X allowed).
- rx_rst falls to 0 in the first cycle after RST deasserts.
- All outputs are registered.
- cfg_req sampled at edge t (legal) → cfg_busy=1 from t+1.
- cfg_err pulses at t+1 for an illegal request.
- Apply cycle: at the edge that enters APPLY, the config outputs update, rx_rst=1 and cfg_ack=1, all for one cycle. At the next edge rx_rst=0, cfg_ack=0, cfg_busy=0.
- Minimum request-to-ack latency: IDLE_BITS*Prescale+2 cycles, with RX_IN continuously high.
- data_valid at edge t (FIFO empty) → m_valid=1 and m_data=P_DATA at t+1.
- Pop at edge t → next entry (or m_valid=0) at t+1.
- overflow asserts the cycle after the dropped byte.

## Test plan
- Reset, then hold RX_IN=1 → Prescale=8, PAR_EN=1, PAR_TYP=0, rx_rst=1 during RST and 0 after, m_valid=0.
- cfg_req with prescale 16, par_en 0, par_typ 1; RX_IN high → cfg_ack exactly 90 cycles after the request edge (11*8+2), with rx_rst high in that same cycle; outputs then read 16/0/1.
- Same request, but RX_IN pulsed low at cycle 50 → idle count restarts; cfg_ack 88 cycles after the low pulse ends.
- cfg_req with prescale 12 → cfg_err pulse, cfg_busy stays 0, config unchanged. Second cfg_req during WAIT_IDLE → ignored.
- Push 0xA1,0xB2,0xC3,0xD4 with m_ready=0, then push 0xE5 → fifo_count=4, overflow=1. Pops return A1..D4 in order. ovf_clr coinciding with a new drop → overflow stays 1.
- FIFO full; data_valid 0x55 with m_ready=1 in the same cycle → count remains 4, no overflow, 0x55 at tail.
